bin_to_bcd_seq: RTL and testbench

- Sequential double-dabble (shift-and-add-3) converter: unsigned binary product in, packed BCD out.
- Sits directly downstream of the shift-add multiplier. Takes its 16-bit product `p` on its `done` pulse and feeds the 7-segment scan stage.
- Trades the combinational BCD tree for W clock cycles of latency and one small adjust datapath.

---
 rtl/bin_to_bcd_seq.sv | 107 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble (shift-and-add-3) converter.
// Converts one W-bit unsigned value into DIGITS packed BCD digits.
// It performs one iteration per clock and takes W clocks per conversion.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; bcd holds the last completed result
// SHIFT | one adjust+shift iteration per edge, W iterations in total
module bin_to_bcd_seq #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam int            SW       = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [W-1:0]    bin_q,   bin_d;
  logic [SW-1:0]   scr_q,   scr_d;
  logic [SW-1:0]   bcd_q,   bcd_d;
  logic            done_q,  done_d;

  logic [SW-1:0]   scr_adj;
  logic [SW-1:0]   scr_shift;

  // Add 3 to every scratch digit >= 5. Each digit is adjusted on its own,
  // with no carry passed between digits.
  always_comb begin
    scr_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      scr_adj[4*i +: 4] = scr_q[4*i +: 4] +
                          ((scr_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
    scr_shift = {scr_adj[SW-2:0], bin_q[W-1]};
  end

  // Next-state logic: capture on accept, iterate, and publish the result on the last pass.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift;
        bin_d = {bin_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          bcd_d   = scr_shift;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. A reset clears everything, which also aborts a conversion in flight.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;
  assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed vector table plus hand-written multi-cycle sequences.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [9];

  bin_to_bcd_seq #(.W(16), .DIGITS(5)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one conversion and follow it through to its done pulse.
  task automatic run_conv(input logic [15:0] v, input logic [19:0] exp, input logic [19:0] prev);
    int n, busy_n;
    bit seen, hold_ok;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 16'($urandom);
    n = 0; busy_n = 0; seen = 0; hold_ok = 1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else begin
        if (busy) busy_n++;
        if (bcd !== prev) hold_ok = 0;
      end
    end
    chk("done_seen", 32'(seen), 1);
    chk("busy_cycles", busy_n, 16);
    chk("bcd_result", 32'(bcd), 32'(exp));
    chk("busy_at_done", 32'(busy), 0);
    chk("bcd_hold_prev", 32'(hold_ok), 1);
    @(negedge clk);
    chk("done_width", 32'(done), 0);
  endtask

  initial begin
    logic [19:0] prev;
    int n, dn;

    vecs[0] = '{16'd186,   20'h00186};
    vecs[1] = '{16'd0,     20'h00000};
    vecs[2] = '{16'd65535, 20'h65535};
    vecs[3] = '{16'd15625, 20'h15625};
    vecs[4] = '{16'd1234,  20'h01234};
    vecs[5] = '{16'd9999,  20'h09999};
    vecs[6] = '{16'd10000, 20'h10000};
    vecs[7] = '{16'd1,     20'h00001};
    vecs[8] = '{16'd4096,  20'h04096};

    clrn  = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    clrn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);

    // Table-driven conversions; each checks that bcd holds the previous result until done.
    prev = 20'h00000;
    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].bin, vecs[i].exp, prev);
      prev = vecs[i].exp;
    end

    // start pulses while busy must be ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd186;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = 16'd999;
    n = 0; dn = 0;
    repeat (30) begin
      @(negedge clk);
      n++;
      start = (n == 3 || n == 10);
      if (done) begin
        dn++;
        chk("ign_bcd", 32'(bcd), 32'h00186);
        chk("ign_latency", n, 17);
      end
    end
    start = 1'b0;
    chk("ign_done_count", dn, 1);
    chk("ign_idle", 32'(busy), 0);

    // A held-high start re-triggers once per completion, every 17 cycles.
    @(negedge clk);
    start = 1'b1;
    bin   = 16'd1234;
    n = 0; dn = 0;
    repeat (55) begin
      @(negedge clk);
      n++;
      chk("held_busy_vs_done", 32'(busy), 32'(!done));
      if (done) begin
        dn++;
        chk("held_period", n, 17 * dn);
        chk("held_bcd", 32'(bcd), 32'h01234);
      end
    end
    chk("held_done_count", dn, 3);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("held_drain", 32'(busy), 0);
    @(negedge clk);

    // Reset in the middle of a conversion aborts it.
    start = 1'b1;
    bin   = 16'd65535;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    clrn = 1'b0;
    #1;
    chk("midrst_bcd", 32'(bcd), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("midrst_no_activity", dn, 0);
    chk("midrst_bcd_after", 32'(bcd), 0);

    run_conv(16'd42, 20'h00042, 20'h00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
